// File: rtl/steak_cook_fsm.sv
`default_nettype none
// steak_cook_fsm: grill controller that times each side of a steak, reports the
// doneness of the rarer side and scores the steak on serve, or zero if it burns.
module steak_cook_fsm #(
    parameter int unsigned RARE_T   = 3,
    parameter int unsigned MEDIUM_T = 6,
    parameter int unsigned WELL_T   = 9,
    parameter int unsigned BURN_T   = 12
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       place,
    input  logic       flip,
    input  logic       serve,
    output logic       cooking,
    output logic       side,
    output logic [1:0] doneness,
    output logic       burnt,
    output logic       score_valid,
    output logic [6:0] score
);

    localparam logic [3:0] RARE_S   = 4'(RARE_T);
    localparam logic [3:0] MEDIUM_S = 4'(MEDIUM_T);
    localparam logic [3:0] WELL_S   = 4'(WELL_T);
    localparam logic [3:0] BURN_S   = 4'(BURN_T);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        DONE  = 2'd2,
        BURNT = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] sec_a;
    logic [3:0] sec_b;
    logic [3:0] sec_a_nxt;
    logic [3:0] sec_b_nxt;
    logic       side_nxt;
    logic [6:0] score_nxt;
    logic       score_valid_nxt;

    logic [1:0] level_a;
    logic [1:0] level_b;
    logic [1:0] level_diff;
    logic [6:0] base_score;
    logic [6:0] serve_score;
    logic [3:0] sec_down;
    logic [3:0] sec_down_inc;

    function automatic logic [1:0] level_of(input logic [3:0] s);
        if (s < RARE_S)        return 2'd0;
        else if (s < MEDIUM_S) return 2'd1;
        else if (s < WELL_S)   return 2'd2;
        else                   return 2'd3;
    endfunction

    assign level_a    = level_of(sec_a);
    assign level_b    = level_of(sec_b);
    assign doneness   = (level_a < level_b) ? level_a : level_b;
    assign level_diff = (level_a > level_b) ? (level_a - level_b) : (level_b - level_a);

    // Medium is the ideal; well is over-cooked and scores below medium.
    always_comb begin
        base_score = 7'd0;
        case (doneness)
            2'd0:    base_score = 7'd0;
            2'd1:    base_score = 7'd50;
            2'd2:    base_score = 7'd100;
            default: base_score = 7'd75;
        endcase
    end

    assign serve_score = (level_diff > 2'd1) ? (base_score >> 1) : base_score;

    assign sec_down     = side ? sec_b : sec_a;
    assign sec_down_inc = (sec_down >= BURN_S) ? BURN_S : (sec_down + 4'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            sec_a       <= 4'd0;
            sec_b       <= 4'd0;
            side        <= 1'b0;
            score       <= 7'd0;
            score_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            sec_a       <= sec_a_nxt;
            sec_b       <= sec_b_nxt;
            side        <= side_nxt;
            score       <= score_nxt;
            score_valid <= score_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        sec_a_nxt       = sec_a;
        sec_b_nxt       = sec_b;
        side_nxt        = side;
        score_nxt       = score;
        score_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (place) begin
                    state_nxt = COOK;
                    sec_a_nxt = 4'd0;
                    sec_b_nxt = 4'd0;
                    side_nxt  = 1'b0;
                end
            end
            COOK: begin
                // Serve freezes the counters, so the score uses pre-tick values.
                if (serve) begin
                    state_nxt       = DONE;
                    score_nxt       = serve_score;
                    score_valid_nxt = 1'b1;
                end else begin
                    // The tick is credited to the side that was down before any flip.
                    if (tick) begin
                        if (side) sec_b_nxt = sec_down_inc;
                        else      sec_a_nxt = sec_down_inc;
                        if (sec_down_inc == BURN_S) begin
                            state_nxt       = BURNT;
                            score_nxt       = 7'd0;
                            score_valid_nxt = 1'b1;
                        end
                    end
                    if (flip) side_nxt = ~side;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            BURNT: begin
                if (serve) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cooking = (state == COOK);
    assign burnt   = (state == BURNT);

endmodule
`default_nettype wire
